// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS run monitor: FSM encoding, trace-entry kinds and layout.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam logic TR_KIND_REG = 1'b0;
  localparam logic TR_KIND_MEM = 1'b1;

  // Default trace-entry geometry; the monitor re-derives the layout from its own parameters.
  localparam int TR_ADDR_W = 32;
  localparam int TR_DATA_W = 32;
  localparam int TR_CYC_W  = 16;

  typedef struct packed {
    logic                 kind;
    logic [TR_ADDR_W-1:0] addr;
    logic [TR_DATA_W-1:0] data;
    logic [TR_CYC_W-1:0]  cycle;
  } trace_entry_t;

endpackage

// File: rtl/mips_trace_fifo.sv
// Trace FIFO: up to two pushes per cycle (slot a lands first), one show-ahead pop.
module mips_trace_fifo #(
  parameter int  DEPTH   = 16,
  parameter type entry_t = mips_pkg::trace_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push_a,
  input  entry_t                 ent_a,
  input  logic                   push_b,
  input  entry_t                 ent_b,
  input  logic                   pop,
  output entry_t                 head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    n_push;
  logic          do_pop;

  assign n_push = {1'b0, push_a} + {1'b0, push_b};
  assign do_pop = pop && valid;
  assign valid  = (count != '0);
  // An empty FIFO presents an all-zero entry so tr_* read back as zero after reset or clear.
  assign head   = valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; clear empties the FIFO at the start of a run.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + (AW+1)'(n_push) - (AW+1)'(do_pop);
    end
  end

  // Entry storage; slot b goes directly behind slot a when both are pushed.
  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr] <= ent_a;
    if (push_b) mem[wr_ptr + AW'(push_a)] <= ent_b;
  end

endmodule

// File: rtl/mips_run_monitor.sv
// Run monitor beside the MIPS pipeline: traces register writes and stores, detects halt/timeout.
module mips_run_monitor
  import mips_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int REG_AW      = 5,
  parameter int DEPTH       = 16,
  parameter int CYC_W       = 16,
  parameter int HALT_CYCLES = 8,
  parameter int MAX_CYCLES  = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc,
  input  logic              rf_we,
  input  logic [REG_AW-1:0] rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              tr_valid,
  input  logic              tr_ready,
  output logic              tr_kind,
  output logic [ADDR_W-1:0] tr_addr,
  output logic [DATA_W-1:0] tr_data,
  output logic [CYC_W-1:0]  tr_cycle,
  output logic [1:0]        state,
  output logic [CYC_W-1:0]  cycle_count,
  output logic [CYC_W-1:0]  wb_count,
  output logic [CYC_W-1:0]  st_count,
  output logic              overflow,
  output logic              done,
  output logic              timeout
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic              kind;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [CYC_W-1:0]  cycle;
  } entry_t;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + CYC_W'(1);
  endfunction

  state_e            cur_st, nxt_st;
  logic [ADDR_W-1:0] last_pc;
  logic [CYC_W-1:0]  stable_cnt;
  logic              run, enter_run, pc_same, halt_hit, tmo_hit;
  logic              reg_ev, st_ev, push_reg, push_st, drop;
  logic [AW:0]       fifo_count, free;
  logic              fifo_valid;
  entry_t            reg_ent, st_ent, head;

  // Next-state: restart from any idle state, halt beats timeout when both fire together.
  always_comb begin
    run       = (cur_st == ST_RUN);
    enter_run = !run && start;
    pc_same   = (pc == last_pc);
    halt_hit  = run && pc_same && (stable_cnt == CYC_W'(HALT_CYCLES-1));
    // Timeout fires on the cycle whose increment brings cycle_count to MAX_CYCLES-1.
    tmo_hit   = run && (sat_inc(cycle_count) == CYC_W'(MAX_CYCLES-1));
    nxt_st    = cur_st;
    if (enter_run)     nxt_st = ST_RUN;
    else if (halt_hit) nxt_st = ST_DONE;
    else if (tmo_hit)  nxt_st = ST_TIMEOUT;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) cur_st <= ST_IDLE;
    else       cur_st <= nxt_st;
  end

  // Capture arbitration against pre-pop free space; the register write takes the last slot.
  always_comb begin
    reg_ev   = run && rf_we && (rf_waddr != '0);
    st_ev    = run && mem_we;
    free     = (AW+1)'(DEPTH) - fifo_count;
    push_reg = reg_ev && (free != '0);
    push_st  = st_ev && (reg_ev ? (free > (AW+1)'(1)) : (free != '0));
    drop     = (reg_ev && !push_reg) || (st_ev && !push_st);

    reg_ent       = '0;
    reg_ent.kind  = TR_KIND_REG;
    reg_ent.addr  = ADDR_W'(rf_waddr);
    reg_ent.data  = rf_wdata;
    reg_ent.cycle = cycle_count;

    st_ent        = '0;
    st_ent.kind   = TR_KIND_MEM;
    st_ent.addr   = mem_addr;
    st_ent.data   = mem_wdata;
    st_ent.cycle  = cycle_count;
  end

  // Run counters, halt detector and sticky overflow; all cleared on run entry.
  always_ff @(posedge clk) begin
    if (reset || enter_run) begin
      cycle_count <= '0;
      wb_count    <= '0;
      st_count    <= '0;
      stable_cnt  <= '0;
      overflow    <= 1'b0;
    end else if (run) begin
      cycle_count <= sat_inc(cycle_count);
      stable_cnt  <= pc_same ? sat_inc(stable_cnt) : '0;
      if (push_reg) wb_count <= sat_inc(wb_count);
      if (push_st)  st_count <= sat_inc(st_count);
      if (drop)     overflow <= 1'b1;
    end
  end

  // Reference PC for the halt detector; loaded on run entry and whenever the PC moves.
  always_ff @(posedge clk) begin
    if (enter_run || (run && !pc_same)) last_pc <= pc;
  end

  mips_trace_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .clear  (enter_run),
    .push_a (push_reg),
    .ent_a  (reg_ent),
    .push_b (push_st),
    .ent_b  (st_ent),
    .pop    (tr_ready),
    .head   (head),
    .valid  (fifo_valid),
    .count  (fifo_count)
  );

  assign tr_valid = fifo_valid;
  assign tr_kind  = head.kind;
  assign tr_addr  = head.addr;
  assign tr_data  = head.data;
  assign tr_cycle = head.cycle;
  assign state    = cur_st;
  assign done     = (cur_st == ST_DONE);
  assign timeout  = (cur_st == ST_TIMEOUT);

endmodule

// File: doc/mips_run_monitor.md
Name: mips_run_monitor

Overview:
- Parametrised run monitor that sits beside the MIPS5 pipeline core, observing its writeback and store ports.
- Logs every architectural register write and memory store into a trace FIFO. Each entry is timestamped with a cycle counter.
- Detects end-of-program as a branch-to-self halt (PC stable), or aborts on a cycle timeout.
- Replaces fixed-delay bench runs: benches drain the trace and wait on done/timeout instead of waiting a fixed number of ns.

Parameters:
DATA_W, 32, width of register/memory data
ADDR_W, 32, width of PC and memory byte address
REG_AW, 5, register-file address width
DEPTH, 16, trace FIFO entries (power of two, >=2)
CYC_W, 16, width of cycle and event counters
HALT_CYCLES, 8, consecutive cycles of unchanged PC that signal halt (>=2)
MAX_CYCLES, 1000, cycle budget before timeout (< 2^CYC_W)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin/restart a monitored run
pc  in  ADDR_W  fetch-stage PC of the core
rf_we  in  1  register-file write enable (WB stage)
rf_waddr  in  REG_AW  register write address
rf_wdata  in  DATA_W  register write data
mem_we  in  1  data-memory write enable (MEM stage)
mem_addr  in  ADDR_W  data-memory address
mem_wdata  in  DATA_W  store data
tr_valid  out  1  trace entry available
tr_ready  in  1  consumer accepts entry
tr_kind  out  1  0 = register write, 1 = store
tr_addr  out  ADDR_W  register number (zero-extended) or memory address
tr_data  out  DATA_W  written value
tr_cycle  out  CYC_W  cycle_count when the event was captured
state  out  2  IDLE=0, RUN=1, DONE=2, TIMEOUT=3
cycle_count  out  CYC_W  cycles spent in RUN
wb_count  out  CYC_W  register writes logged
st_count  out  CYC_W  stores logged
overflow  out  1  sticky: at least one event dropped
done  out  1  state==DONE
timeout  out  1  state==TIMEOUT

Behaviour:
- Reset: state=IDLE, all counters 0, FIFO empty, tr_valid=0, tr_kind/tr_addr/tr_data/tr_cycle=0, overflow=0, done=timeout=0. Reset wins over every other input, including mid-run.
- FSM transitions:
  - IDLE/DONE/TIMEOUT + start -> RUN. On entry: counters, FIFO, overflow and stable-PC counter are cleared; last_pc is loaded from pc.
  - start while in RUN is ignored.
  - RUN: stable counter increments when pc==last_pc, else it resets to 0 and last_pc updates.
  - RUN -> DONE: stable counter reaches HALT_CYCLES-1 and pc==last_pc.
  - RUN -> TIMEOUT: cycle_count reaches MAX_CYCLES-1.
  - Halt and timeout on the same cycle: DONE wins.
- cycle_count increments every RUN cycle and freezes outside RUN.
- Capture happens in RUN only, including the transition cycle.
  - Register writes with rf_waddr==0 are not logged and not counted.
  - Capture is combinational on the sampled inputs. An entry becomes visible on tr_* one cycle after capture (registered FIFO write, show-ahead read).
- FIFO free space is computed from the pre-pop count; a pop in the same cycle gives no credit.
  - Both events, free>=2: register entry is written first, store second.
  - Both events, free==1: register entry accepted, store dropped.
  - One event, free==0: event dropped.
  - Any drop sets overflow. wb_count/st_count count accepted entries only.
- Handshake: pop when tr_valid && tr_ready. tr_* stay stable while tr_valid && !tr_ready.
- Draining continues in DONE/TIMEOUT; no new captures occur there.
- Counters saturate at 2^CYC_W-1.

Decomposition:
- Shared package mips_pkg: state encoding (ST_IDLE..ST_TIMEOUT), TR_KIND_REG/TR_KIND_MEM constants, trace-entry struct {kind, addr, data, cycle}.
- Sub-module mips_trace_fifo: parametrised DEPTH, dual-push (0/1/2 per cycle), single show-ahead pop, count output.
- The top holds the FSM, halt detector and counters.

Test Plan:
- Halt detection: reset, start, pc increments by 4 for 20 cycles then holds at 0x50 -> DONE asserted exactly 8 cycles after pc first repeats; cycle_count frozen.
- Writeback trace: writes $1=1, $2=1, $3=2, $0=5 at RUN cycles 2,3,4,5 with tr_ready=1 -> three entries (kind 0) with addr 1/2/3, data 1/1/2, tr_cycle 2/3/4; wb_count=3.
- Dual push: rf write $4=3 and store Mem[8]=3 in the same cycle -> two entries, register first then {kind 1, addr 8, data 3}; st_count=1.
- Overflow: tr_ready=0, 17 single register writes with DEPTH=16 -> 16 entries retained, overflow=1. Then drain -> values in order and tr_* stable while stalled.
- Timeout: pc toggles every cycle with MAX_CYCLES=50 -> TIMEOUT at cycle_count=49. A halt coinciding with the timeout cycle yields DONE instead.
- Restart/reset: start from DONE clears counters and FIFO, returns to RUN. Reset asserted mid-run -> IDLE next edge, tr_valid=0, all counters 0.
